// File: rtl/gates_checker_pkg.sv
// Shared types and golden truth-table values for the gates response checker.
// The FSM state encoding, vector count and expected x per input code live here.
package gates_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // XNOR(0,0) and both inverters are high for a=00, so bits 7,6,5 are all set
    localparam logic [7:0] EXP_00 = 8'hEA;
    localparam logic [7:0] EXP_01 = 8'h96;
    localparam logic [7:0] EXP_10 = 8'h56;
    localparam logic [7:0] EXP_11 = 8'h25;

    localparam int unsigned NUM_VECTORS = 4;

    function automatic logic [7:0] expected_x(input logic [1:0] a);
        logic [7:0] result;
        unique case (a)
            2'b00:   result = EXP_00;
            2'b01:   result = EXP_01;
            2'b10:   result = EXP_10;
            default: result = EXP_11;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gates_checker_if.sv
// Stimulus/response and result bundle between the checker and its host.
// The slave side is the checker itself; the master side drives start and x_in.
interface gates_checker_if;

    logic       start;
    logic [1:0] a_out;
    logic [7:0] x_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [7:0] fail_vec;
    logic [1:0] first_fail_a;

    modport master (
        output start,
        output x_in,
        input  a_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_count,
        input  fail_vec,
        input  first_fail_a
    );

    modport slave (
        input  start,
        input  x_in,
        output a_out,
        output busy,
        output done,
        output pass,
        output fail_count,
        output fail_vec,
        output first_fail_a
    );

endinterface

// File: rtl/gates_checker_ref.sv
// Combinational golden model of the gates block: maps a[1:0] to the expected x[7:0].
// Kept standalone so benches and other checkers can reuse it.
module gates_ref
    import gates_pkg::*;
(
    input  logic [1:0] a,
    output logic [7:0] exp_x
);

    assign exp_x = expected_x(a);

endmodule

// File: rtl/gates_checker.sv
// On-chip sweep checker for the gates block: steps a through 00..11, waits a settle
// interval per step, compares x against the golden table and latches the results.
module gates_checker
    import gates_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic            clk,
    input logic            rst_n,
    gates_checker_if.slave bus
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_A = 2'(NUM_VECTORS - 1);

    state_t     state_q, state_d;
    logic [1:0] a_q, a_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] fail_count_q, fail_count_d;
    logic [7:0] fail_vec_q, fail_vec_d;
    logic [1:0] first_fail_a_q, first_fail_a_d;
    logic       pass_q, pass_d;

    logic [7:0] exp_x;
    logic [7:0] mismatch;

    gates_ref u_ref (
        .a     (a_q),
        .exp_x (exp_x)
    );

    assign mismatch = bus.x_in ^ exp_x;

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        cnt_d          = cnt_q;
        fail_count_d   = fail_count_q;
        fail_vec_d     = fail_vec_q;
        first_fail_a_d = first_fail_a_q;
        pass_d         = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A new sweep clears every result in the same edge that samples start
                if (bus.start) begin
                    state_d        = SETTLE;
                    a_d            = 2'b00;
                    cnt_d          = RELOAD;
                    fail_count_d   = 3'd0;
                    fail_vec_d     = 8'h00;
                    first_fail_a_d = 2'b00;
                    pass_d         = 1'b0;
                end
            end

            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            CHECK: begin
                if (mismatch != 8'h00) begin
                    fail_count_d = fail_count_q + 3'd1;
                    fail_vec_d   = fail_vec_q | mismatch;
                    if (fail_count_q == 3'd0) begin
                        first_fail_a_d = a_q;
                    end
                end
                if (a_q == LAST_A) begin
                    state_d = DONE;
                    pass_d  = (fail_count_d == 3'd0);
                end else begin
                    state_d = SETTLE;
                    a_d     = a_q + 2'd1;
                    cnt_d   = RELOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            a_q            <= 2'b00;
            cnt_q          <= 8'd0;
            fail_count_q   <= 3'd0;
            fail_vec_q     <= 8'h00;
            first_fail_a_q <= 2'b00;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            cnt_q          <= cnt_d;
            fail_count_q   <= fail_count_d;
            fail_vec_q     <= fail_vec_d;
            first_fail_a_q <= first_fail_a_d;
            pass_q         <= pass_d;
        end
    end

    assign bus.a_out        = a_q;
    assign bus.busy         = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done         = (state_q == DONE);
    assign bus.pass         = pass_q;
    assign bus.fail_count   = fail_count_q;
    assign bus.fail_vec     = fail_vec_q;
    assign bus.first_fail_a = first_fail_a_q;

endmodule
